id_hazard_ctrl: RTL and testbench
=================================

ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, register address width; scoreboard depth 2**REG_ADDR_WIDTH.
REQ-003 Parameter FWD_STAGES, default 3, number of forwarding sources; index 0 youngest.
REQ-004 Parameter CNT_WIDTH, default 16, stall-counter width.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rst_n  in  1  reset; asynchronous, active-low.
REQ-007 d_valid_i  in  1  decode holds a valid instruction.
REQ-008 d_rs1_addr_i, d_rs2_addr_i  in  REG_ADDR_WIDTH each  source addresses.
REQ-009 d_use_rs1_i, d_use_rs2_i  in  1 each  instruction reads rs1/rs2.
REQ-010 d_rs1_data_i, d_rs2_data_i  in  DATA_WIDTH each  regfile read data.
REQ-011 d_rd_addr_i  in  REG_ADDR_WIDTH; d_rd_wr_i  in  1  destination and write enable.
REQ-012 d_is_mc_i  in  1  multi-cycle op; result returns via mc_* port.
REQ-013 fwd_wr_i  in  FWD_STAGES; fwd_addr_i  in  FWD_STAGES*REG_ADDR_WIDTH; fwd_data_i  in  FWD_STAGES*DATA_WIDTH; fwd_ld_pend_i  in  FWD_STAGES  (stage holds load, data not valid).
REQ-014 mc_done_i  in  1; mc_rd_addr_i  in  REG_ADDR_WIDTH; mc_rd_data_i  in  DATA_WIDTH  multi-cycle writeback.
REQ-015 flush_i  in  1  kill decode and execute-register contents.
REQ-016 e_ready_i  in  1  execute accepts e_* this cycle.
REQ-017 d_ready_o  out  1  decode instruction issued this cycle (combinational).
REQ-018 e_valid_o  out  1; e_rs1_o, e_rs2_o  out  DATA_WIDTH; e_rd_addr_o  out  REG_ADDR_WIDTH; e_rd_wr_o  out  1; e_is_mc_o  out  1  registered issue.
REQ-019 stall_o  out  1  hazard stall (combinational); sb_busy_o  out  1  any scoreboard bit set.
REQ-020 stall_cnt_o  out  CNT_WIDTH  saturating count of stall cycles.

Function
REQ-021 Operand select per source, priority: address 0 -> 0; fwd stage i with fwd_wr_i[i] & addr match, lowest i first; mc_done_i & mc_rd_addr_i match; regfile data.
REQ-022 Load hazard: used source matches a stage with fwd_wr_i[i] & fwd_ld_pend_i[i], addr != 0.
REQ-023 Scoreboard RAW hazard: used source != 0 with scoreboard bit set and not cleared by mc_done_i this cycle.
REQ-024 WAW hazard: d_rd_wr_i, rd != 0, scoreboard[rd] set and not cleared this cycle.
REQ-025 stall_o = d_valid_i & any hazard & !flush_i.
REQ-026 issue = d_valid_i & !stall_o & !flush_i & (e_ready_i | !e_valid_o); d_ready_o = issue.
REQ-027 On issue, e_* loaded with selected operands and decode fields, e_valid_o 1 next cycle; 1-cycle latency.
REQ-028 No issue & e_ready_i: e_valid_o 0 next cycle (bubble); no issue & !e_ready_i: e_* held.
REQ-029 flush_i: e_valid_o 0 next cycle; no issue; scoreboard unchanged (in-flight mc ops complete).
REQ-030 Scoreboard set on issue with d_is_mc_i & d_rd_wr_i & rd != 0; cleared on mc_done_i at mc_rd_addr_i; same-address set and clear same cycle: set wins; bit 0 never set.
REQ-031 stall_cnt_o increments each cycle stall_o = 1; holds at all-ones.

Reset
REQ-032 rst_n low: all e_* outputs 0, scoreboard 0, stall_cnt_o 0, independent of clk; mid-operation reset drops in-flight scoreboard state.

Verification
REQ-033 x1 in fwd stage 0 = 0x11, stage 2 = 0x22, regfile 0x33; read rs1=x1 -> e_rs1_o 0x11.
REQ-034 Read rs2=x0 while fwd stage 0 writes x0 = 0xFF -> e_rs2_o 0.
REQ-035 Stage 1 load pending to x5, decode uses x5 -> stall_o 1, no issue, stall_cnt_o +1; pend drops -> issue next cycle.
REQ-036 Issue mc op rd=x7 -> sb_busy_o 1; next op reads x7 stalls until mc_done_i x7 data 0xABCD -> issues same cycle with e_rs1_o 0xABCD, sb_busy_o 0.
REQ-037 e_ready_i 0 for 3 cycles with e_valid_o 1 -> e_* held, d_ready_o 0; flush_i -> e_valid_o 0 next cycle, scoreboard kept.
REQ-038 Force 2**CNT_WIDTH+5 stall cycles -> stall_cnt_o all-ones; assert rst_n low mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: operand forwarding, load/scoreboard stalls,
// and a registered issue slot toward execute.
module id_hazard_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FWD_STAGES     = 3,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               d_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]          d_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0]          d_rs2_addr_i,
  input  logic                               d_use_rs1_i,
  input  logic                               d_use_rs2_i,
  input  logic [DATA_WIDTH-1:0]              d_rs1_data_i,
  input  logic [DATA_WIDTH-1:0]              d_rs2_data_i,
  input  logic [REG_ADDR_WIDTH-1:0]          d_rd_addr_i,
  input  logic                               d_rd_wr_i,
  input  logic                               d_is_mc_i,
  input  logic [FWD_STAGES-1:0]              fwd_wr_i,
  input  logic [FWD_STAGES*REG_ADDR_WIDTH-1:0] fwd_addr_i,
  input  logic [FWD_STAGES*DATA_WIDTH-1:0]   fwd_data_i,
  input  logic [FWD_STAGES-1:0]              fwd_ld_pend_i,
  input  logic                               mc_done_i,
  input  logic [REG_ADDR_WIDTH-1:0]          mc_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]              mc_rd_data_i,
  input  logic                               flush_i,
  input  logic                               e_ready_i,
  output logic                               d_ready_o,
  output logic                               e_valid_o,
  output logic [DATA_WIDTH-1:0]              e_rs1_o,
  output logic [DATA_WIDTH-1:0]              e_rs2_o,
  output logic [REG_ADDR_WIDTH-1:0]          e_rd_addr_o,
  output logic                               e_rd_wr_o,
  output logic                               e_is_mc_o,
  output logic                               stall_o,
  output logic                               sb_busy_o,
  output logic [CNT_WIDTH-1:0]               stall_cnt_o
);

  localparam int SB_DEPTH = 2**REG_ADDR_WIDTH;

  logic [SB_DEPTH-1:0]   sb;
  logic [SB_DEPTH-1:0]   sb_next;
  logic [DATA_WIDTH-1:0] rs1_sel;
  logic [DATA_WIDTH-1:0] rs2_sel;
  logic                  hazard;
  logic                  issue;

  // Stages are scanned oldest to youngest so the youngest matching writer wins.
  function automatic logic [DATA_WIDTH-1:0] select_operand(
    input logic [REG_ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0]     rf_data
  );
    logic [DATA_WIDTH-1:0] res;
    res = (mc_done_i && (mc_rd_addr_i == addr)) ? mc_rd_data_i : rf_data;
    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      if (fwd_wr_i[i] && (fwd_addr_i[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == addr))
        res = fwd_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
    if (addr == '0)
      res = '0;
    return res;
  endfunction

  function automatic logic load_hit(input logic [REG_ADDR_WIDTH-1:0] addr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < FWD_STAGES; i++) begin
      if (fwd_wr_i[i] && fwd_ld_pend_i[i] &&
          (fwd_addr_i[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == addr))
        hit = 1'b1;
    end
    return hit && (addr != '0);
  endfunction

  // A pending multi-cycle result retiring this very cycle no longer blocks.
  function automatic logic sb_pending(input logic [REG_ADDR_WIDTH-1:0] addr);
    return (addr != '0) && sb[addr] && !(mc_done_i && (mc_rd_addr_i == addr));
  endfunction

  always_comb begin
    rs1_sel = select_operand(d_rs1_addr_i, d_rs1_data_i);
    rs2_sel = select_operand(d_rs2_addr_i, d_rs2_data_i);
    hazard  = (d_use_rs1_i && (load_hit(d_rs1_addr_i) || sb_pending(d_rs1_addr_i))) ||
              (d_use_rs2_i && (load_hit(d_rs2_addr_i) || sb_pending(d_rs2_addr_i))) ||
              (d_rd_wr_i && sb_pending(d_rd_addr_i));
    stall_o   = d_valid_i && hazard && !flush_i;
    issue     = d_valid_i && !stall_o && !flush_i && (e_ready_i || !e_valid_o);
    d_ready_o = issue;
    sb_busy_o = |sb;
  end

  // Set is applied after clear so a same-address set/clear leaves the bit set.
  always_comb begin
    sb_next = sb;
    if (mc_done_i)
      sb_next[mc_rd_addr_i] = 1'b0;
    if (issue && d_is_mc_i && d_rd_wr_i && (d_rd_addr_i != '0))
      sb_next[d_rd_addr_i] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb          <= '0;
      stall_cnt_o <= '0;
    end else begin
      sb <= sb_next;
      if (stall_o && (stall_cnt_o != {CNT_WIDTH{1'b1}}))
        stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
    end
  end

  // Flush and bubbles only drop valid; payload is held until the next issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid_o   <= 1'b0;
      e_rs1_o     <= '0;
      e_rs2_o     <= '0;
      e_rd_addr_o <= '0;
      e_rd_wr_o   <= 1'b0;
      e_is_mc_o   <= 1'b0;
    end else if (flush_i) begin
      e_valid_o <= 1'b0;
    end else if (issue) begin
      e_valid_o   <= 1'b1;
      e_rs1_o     <= rs1_sel;
      e_rs2_o     <= rs2_sel;
      e_rd_addr_o <= d_rd_addr_i;
      e_rd_wr_o   <= d_rd_wr_i;
      e_is_mc_o   <= d_is_mc_i;
    end else if (e_ready_i) begin
      e_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed scenarios plus random
// traffic compared against a rule-level reference model.
module tb_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_valid, use1, use2, rd_wr, is_mc, mc_done, flush, e_ready;
  logic [4:0]  rs1, rs2, rd, mc_addr;
  logic [31:0] rf1, rf2, mc_data;
  logic        fw [3];
  logic        fl [3];
  logic [4:0]  fa [3];
  logic [31:0] fd [3];

  logic        d_ready_o, e_valid_o, e_rd_wr_o, e_is_mc_o, stall_o, sb_busy_o;
  logic [31:0] e_rs1_o, e_rs2_o;
  logic [4:0]  e_rd_addr_o;
  logic [15:0] stall_cnt_o;

  logic [2:0]  fwd_wr, fwd_ld;
  logic [14:0] fwd_addr;
  logic [95:0] fwd_data;
  assign fwd_wr   = {fw[2], fw[1], fw[0]};
  assign fwd_ld   = {fl[2], fl[1], fl[0]};
  assign fwd_addr = {fa[2], fa[1], fa[0]};
  assign fwd_data = {fd[2], fd[1], fd[0]};

  int assertCount = 0;
  int failCount   = 0;

  bit          sb_m [32];
  logic        ev_m, ewr_m, emc_m;
  logic [31:0] e1_m, e2_m;
  logic [4:0]  erd_m;
  int          cnt_m;

  always #5 clk = ~clk;

  id_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .d_valid_i(d_valid), .d_rs1_addr_i(rs1), .d_rs2_addr_i(rs2),
    .d_use_rs1_i(use1), .d_use_rs2_i(use2),
    .d_rs1_data_i(rf1), .d_rs2_data_i(rf2),
    .d_rd_addr_i(rd), .d_rd_wr_i(rd_wr), .d_is_mc_i(is_mc),
    .fwd_wr_i(fwd_wr), .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data),
    .fwd_ld_pend_i(fwd_ld),
    .mc_done_i(mc_done), .mc_rd_addr_i(mc_addr), .mc_rd_data_i(mc_data),
    .flush_i(flush), .e_ready_i(e_ready),
    .d_ready_o(d_ready_o), .e_valid_o(e_valid_o),
    .e_rs1_o(e_rs1_o), .e_rs2_o(e_rs2_o), .e_rd_addr_o(e_rd_addr_o),
    .e_rd_wr_o(e_rd_wr_o), .e_is_mc_o(e_is_mc_o),
    .stall_o(stall_o), .sb_busy_o(sb_busy_o), .stall_cnt_o(stall_cnt_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] modelOperand(input logic [4:0] a, input logic [31:0] rfv);
    if (a == 0) return 32'h0;
    for (int i = 0; i < 3; i++)
      if (fw[i] && fa[i] == a) return fd[i];
    if (mc_done && mc_addr == a) return mc_data;
    return rfv;
  endfunction

  function automatic bit loadHit(input logic [4:0] a);
    if (a == 0) return 1'b0;
    for (int i = 0; i < 3; i++)
      if (fw[i] && fl[i] && fa[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit sbBlocks(input logic [4:0] a);
    return (a != 0) && sb_m[a] && !(mc_done && mc_addr == a);
  endfunction

  function automatic bit modelStall();
    bit hz;
    hz = (use1 && (loadHit(rs1) || sbBlocks(rs1))) ||
         (use2 && (loadHit(rs2) || sbBlocks(rs2))) ||
         (rd_wr && sbBlocks(rd));
    return d_valid && hz && !flush;
  endfunction

  function automatic bit modelBusy();
    for (int i = 0; i < 32; i++)
      if (sb_m[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 32; i++) sb_m[i] = 1'b0;
    ev_m = 0; ewr_m = 0; emc_m = 0; e1_m = 0; e2_m = 0; erd_m = 0; cnt_m = 0;
  endtask

  task automatic clearInputs();
    d_valid = 0; use1 = 0; use2 = 0; rd_wr = 0; is_mc = 0; mc_done = 0;
    flush = 0; e_ready = 1; rs1 = 0; rs2 = 0; rd = 0; mc_addr = 0;
    rf1 = 0; rf2 = 0; mc_data = 0;
    for (int i = 0; i < 3; i++) begin fw[i] = 0; fl[i] = 0; fa[i] = 0; fd[i] = 0; end
  endtask

  task automatic checkRegs();
    checkOutput("e_valid", e_valid_o, ev_m);
    checkOutput("e_rs1", e_rs1_o, e1_m);
    checkOutput("e_rs2", e_rs2_o, e2_m);
    checkOutput("e_rd_addr", e_rd_addr_o, erd_m);
    checkOutput("e_rd_wr", e_rd_wr_o, ewr_m);
    checkOutput("e_is_mc", e_is_mc_o, emc_m);
    checkOutput("sb_busy", sb_busy_o, modelBusy());
    checkOutput("stall_cnt", stall_cnt_o, 64'(cnt_m));
  endtask

  // One clock: inputs are already driven; check combinational outputs,
  // advance the model at the edge, then check registered outputs.
  task automatic applyStimulus();
    bit          exp_stall, exp_issue;
    logic [31:0] o1, o2;
    #1;
    exp_stall = modelStall();
    exp_issue = d_valid && !exp_stall && !flush && (e_ready || !ev_m);
    o1 = modelOperand(rs1, rf1);
    o2 = modelOperand(rs2, rf2);
    checkOutput("stall", stall_o, exp_stall);
    checkOutput("d_ready", d_ready_o, exp_issue);
    @(posedge clk);
    if (flush) ev_m = 0;
    else if (exp_issue) begin
      ev_m = 1; e1_m = o1; e2_m = o2; erd_m = rd; ewr_m = rd_wr; emc_m = is_mc;
    end else if (e_ready) ev_m = 0;
    if (mc_done) sb_m[mc_addr] = 0;
    if (exp_issue && is_mc && rd_wr && rd != 0) sb_m[rd] = 1;
    if (exp_stall && cnt_m < 65535) cnt_m++;
    @(negedge clk);
    checkRegs();
  endtask

  task automatic checkResetZero(input string tag);
    checkOutput({tag, "_e_valid"}, e_valid_o, 0);
    checkOutput({tag, "_e_rs1"}, e_rs1_o, 0);
    checkOutput({tag, "_e_rs2"}, e_rs2_o, 0);
    checkOutput({tag, "_e_rd"}, {e_rd_addr_o, e_rd_wr_o, e_is_mc_o}, 0);
    checkOutput({tag, "_sb_busy"}, sb_busy_o, 0);
    checkOutput({tag, "_stall_cnt"}, stall_cnt_o, 0);
  endtask

  initial begin
    clearInputs();
    resetModel();
    rst_n = 0;
    #3;
    checkResetZero("reset");
    @(negedge clk);
    rst_n = 1;

    // Youngest forwarding stage wins over older stage and regfile.
    d_valid = 1; use1 = 1; rs1 = 1; rf1 = 32'h33;
    fw[0] = 1; fa[0] = 1; fd[0] = 32'h11;
    fw[2] = 1; fa[2] = 1; fd[2] = 32'h22;
    applyStimulus();
    checkOutput("fwd_prio", e_rs1_o, 32'h11);

    clearInputs();
    d_valid = 1; use2 = 1; rs2 = 0; rf2 = 32'h44;
    fw[0] = 1; fa[0] = 0; fd[0] = 32'hFF;
    applyStimulus();
    checkOutput("x0_zero", e_rs2_o, 32'h0);

    // Load-use stall, then release.
    clearInputs();
    d_valid = 1; use1 = 1; rs1 = 5; rf1 = 32'h5;
    fw[1] = 1; fl[1] = 1; fa[1] = 5;
    applyStimulus();
    checkOutput("ld_stall_cnt", stall_cnt_o, 1);
    checkOutput("ld_stall_bubble", e_valid_o, 0);
    fw[1] = 0; fl[1] = 0;
    applyStimulus();
    checkOutput("ld_release", e_valid_o, 1);

    // Multi-cycle op to x7, dependent stall, retire-and-issue.
    clearInputs();
    d_valid = 1; is_mc = 1; rd_wr = 1; rd = 7;
    applyStimulus();
    checkOutput("mc_sb_set", sb_busy_o, 1);
    clearInputs();
    d_valid = 1; use1 = 1; rs1 = 7; rf1 = 32'h1234;
    repeat (2) applyStimulus();
    checkOutput("raw_stall_bubble", e_valid_o, 0);
    mc_done = 1; mc_addr = 7; mc_data = 32'hABCD;
    applyStimulus();
    checkOutput("mc_bypass", e_rs1_o, 32'hABCD);
    checkOutput("mc_sb_clear", sb_busy_o, 0);

    // Backpressure holds e_*, flush drops valid but keeps x9 in flight.
    clearInputs();
    d_valid = 1; use1 = 1; rs1 = 2; rf1 = 32'h55; is_mc = 1; rd_wr = 1; rd = 9;
    applyStimulus();
    checkOutput("bp_issue", e_rs1_o, 32'h55);
    clearInputs();
    e_ready = 0; d_valid = 1; use1 = 1; rs1 = 3; rf1 = 32'h66; rd_wr = 1; rd = 3;
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      checkOutput("bp_hold_rs1", e_rs1_o, 32'h55);
      checkOutput("bp_hold_valid", e_valid_o, 1);
    end
    flush = 1;
    applyStimulus();
    checkOutput("flush_valid", e_valid_o, 0);
    checkOutput("flush_sb_kept", sb_busy_o, 1);

    // Saturating stall counter across 2**16+5 stall cycles.
    clearInputs();
    d_valid = 1; use1 = 1; rs1 = 5; fw[1] = 1; fl[1] = 1; fa[1] = 5;
    applyStimulus();
    repeat (65540) @(posedge clk);
    cnt_m = (cnt_m + 65540 > 65535) ? 65535 : cnt_m + 65540;
    @(negedge clk);
    checkRegs();
    checkOutput("cnt_saturated", stall_cnt_o, 16'hFFFF);

    // Asynchronous reset in the middle of the stall.
    #2 rst_n = 0;
    #1;
    checkResetZero("midreset");
    resetModel();
    @(negedge clk);
    rst_n = 1;
    clearInputs();

    for (int n = 0; n < 500; n++) begin
      d_valid = ($urandom_range(0, 9) < 8);
      use1 = $urandom_range(0, 1); use2 = $urandom_range(0, 1);
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7)); rd_wr = $urandom_range(0, 1);
      is_mc = ($urandom_range(0, 9) < 3);
      rf1 = $urandom; rf2 = $urandom;
      for (int i = 0; i < 3; i++) begin
        fw[i] = $urandom_range(0, 1); fl[i] = ($urandom_range(0, 9) < 2);
        fa[i] = 5'($urandom_range(0, 7)); fd[i] = $urandom;
      end
      mc_done = ($urandom_range(0, 3) == 0); mc_addr = 5'($urandom_range(0, 7));
      mc_data = $urandom;
      flush = ($urandom_range(0, 9) == 0);
      e_ready = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
